// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// One result bit per RUN cycle; FIX applies sign correction and commits HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = ~i_op[0];
  assign w_a_mag  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  // Multiply: accumulator upper half collects partial sums, lower half holds the shifting multiplier.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: bit WIDTH of the trial difference is the borrow, meaning the divisor did not fit.
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
  assign w_div_ok    = ~w_div_trial[WIDTH];
  assign w_div_rem   = w_div_ok ? w_div_trial[WIDTH-1:0] : {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
  assign w_div_next  = {w_div_rem, r_acc[WIDTH-2:0], w_div_ok};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_we) r_hi <= i_wdata;
          if (i_lo_we) r_lo <= i_wdata;
          if (i_start) begin
            if (i_op[1] && (i_b == '0)) begin
              r_done <= 1'b1;
              r_dbz  <= 1'b1;
            end else begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= i_op[1];
              r_neg_q  <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
              r_neg_r  <= w_signed & i_a[WIDTH-1];
              r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
              r_opb    <= i_op[1] ? w_b_mag : w_a_mag;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
// Stimulus pushes expected HI/LO/flag and completion cycle; the monitor pops on every done.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          at;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .i_hi_we       (hi_we),
    .i_lo_we       (lo_we),
    .i_wdata       (wdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_hi          (hi),
    .o_lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dbz && !done) begin
        n_vec++;
        n_err++;
        $display("FAIL dbz_without_done: div_by_zero=1 with done=0 (cycle %0d)", cyc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.at));
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(dbz), 64'(e.dbz));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Called at a negedge; the following posedge is the start edge E0.
  task automatic issue(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dbz);
    exp_t e;
    e.hi  = e_hi;
    e.lo  = e_lo;
    e.dbz = e_dbz;
    e.at  = cyc + (e_dbz ? 1 : 34);
    sb.push_back(e);
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL timeout: %0d operations still pending after 80 cycles", sb.size());
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(dbz), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    cnt = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(cnt), 64'd33);
    wait_idle();

    issue(2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0); wait_idle();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); wait_idle();
    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0); wait_idle();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0); wait_idle();
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0); wait_idle();
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0); wait_idle();

    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("preload_hi", 64'(hi), 64'h1234);
    chk("preload_lo", 64'(lo), 64'h5678);
    issue(2'd2, 32'd5, 32'd0, 32'h1234, 32'h5678, 1'b1);
    chk("dbz_busy", 64'(busy), 64'd0);
    wait_idle();

    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("hi_write_while_busy", 64'(hi), 64'h1234);
    repeat (28) @(negedge clk);
    chk("first_done_position", 64'(done), 64'd1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0);
    wait_idle();

    hi_we = 1'b1; wdata = 32'hDEAD;
    issue(2'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    hi_we = 1'b0;
    chk("write_with_start", 64'(hi), 64'hDEAD);
    wait_idle();

    hi_we = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    hi_we = 1'b0;
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_hi", 64'(hi), 64'd0);
    chk("midrun_reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'd3, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
